if_prefetch: RTL and testbench
==============================

# if_prefetch

Instruction prefetch unit that sits directly upstream of the IF stage of the five-stage CPU. It sits between a variable-latency instruction memory port (req/ack handshake) and the fetch stage. It fetches sequential words into a small FIFO and presents `inst`, `pc` and `pc4` to the IF/ID pipeline register. It obeys the pipeline's stall (`hold`) and branch/jump redirect (`redirect`) signals.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'd0: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  fetch request to instruction memory (registered).
- `mem_addr`  out  32  word address of the request (registered; bits [1:0] always 0).
- `mem_ack`  in  1  memory accepts the request and returns `mem_rdata` in the same cycle.
- `mem_rdata`  in  32  instruction word, valid only when `mem_req && mem_ack`.
- `hold`  in  1  pipeline stall; the head entry is not consumed.
- `redirect`  in  1  branch/jump taken; flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- `inst`  out  32  instruction at the FIFO head; reads 0 when `valid`=0.
- `pc`  out  32  address of `inst`; reads 0 when `valid`=0.
- `pc4`  out  32  `pc`+4, modulo 2^32; reads 0 when `valid`=0.
- `valid`  out  1  the FIFO head holds an instruction (count != 0).
- `count`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Each FIFO entry holds {pc, inst}. Internal state: `fetch_pc`, read/write pointers, `count`, and a three-state FSM: IDLE, REQ, DROP.
- A pop happens at a clock edge when `valid && !hold && !redirect`.
- A push happens at a clock edge when state=REQ, `mem_ack`=1 and `redirect`=0. The entry written is {mem_addr, mem_rdata}. Push and pop may occur on the same edge.
- `room` means that `count`, after this edge's push and pop, is less than DEPTH.
- IDLE: `mem_req`=0.
  - `redirect`: load `fetch_pc` with the new address; stay in IDLE.
  - Otherwise, if `room`: go to REQ with `mem_addr`=`fetch_pc`.
- REQ: `mem_req`=1. `mem_addr` stays stable until ack.
  - `mem_ack` and no `redirect`: push; `fetch_pc` += 4. Go to REQ at the next address if `room`, otherwise go to IDLE.
  - `mem_ack` and `redirect`: discard the data; load `fetch_pc` with the new address; go to REQ at that address (the FIFO is now empty, so there is room).
  - No ack and `redirect`: go to DROP. `mem_req` and `mem_addr` are unchanged; `fetch_pc` is loaded with the new address.
- DROP: `mem_req`=1 with the old address. This is required because a request must not be withdrawn before ack.
  - `redirect` again: update `fetch_pc`.
  - On `mem_ack`: discard `mem_rdata`; go to REQ with `mem_addr`=`fetch_pc`.
- `redirect` at any state clears the FIFO at that edge (`count`=0, pointers equal). `redirect` has priority over `hold`, pop and push.
- Invariant: a push never occurs while `count`=DEPTH. Overflow is impossible by construction; the bench asserts this invariant.
- Address arithmetic is 32-bit and wraps from 32'hFFFFFFFC to 0.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=RESET_PC, `fetch_pc`=RESET_PC.
  - `valid`=0, `count`=0, `inst`=`pc`=`pc4`=0.
  - FSM in IDLE.
- Reset asserted mid-request drops `mem_req` immediately (asynchronously). Instruction memory must tolerate an abandoned request.
- First edge after reset release: go to REQ, and `mem_req` rises.
- With a zero-wait memory (`mem_ack` tied 1), `valid` rises on the second edge with `pc`=RESET_PC. Sustained rate is one instruction per cycle.
- Fetch-to-output latency equals the memory ack latency plus 1 cycle.
- A redirect asserted at edge N gives `valid`=0 after N. With zero-wait memory, `valid` returns at N+1 with `pc`=`redirect_pc`.
- In DROP, this is delayed by the remaining ack latency of the abandoned request.
- Outputs `inst`, `pc`, `pc4` and `valid` are combinational from the head register and `count`, with no input-to-output combinational path.

## Test plan
- Reset release, `mem_ack`=1, `hold`=0 -> `valid`=1 on edge 2; `pc` = 0, 4, 8, … on successive cycles; `inst` matches the memory model.
- `hold`=1 for 10 cycles, `mem_ack`=1 -> `count` saturates at 4 and `mem_req` falls. After `hold` is released, the output is 0, 4, 8, 12, 16 with no gap and no duplicates.
- Memory with 3-cycle ack; `redirect` with `redirect_pc`=32'h40 one cycle after `mem_req` rises -> DROP entered. The old word is discarded; the next `mem_addr` is 32'h40; the first valid `pc` is 32'h40.
- `redirect` with `redirect_pc`=32'h100 in the same cycle as `mem_ack` and a pop -> FIFO empty, data discarded. Next `mem_addr` is 32'h100; no stale `pc` ever appears.
- `RESET_PC`=32'hFFFFFFF8 -> `pc` sequence is FFFFFFF8, FFFFFFFC, 0, 4; `pc4` at FFFFFFFC reads 0.
- `reset` asserted while in REQ with `mem_ack`=0 -> `mem_req`, `valid` and `count` go to 0 immediately. After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_if.sv
// Bundles the instruction-memory handshake and the fetch-stage signals of the
// prefetch unit. The master side is the prefetch unit itself.
interface if_prefetch_if #(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          hold;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [31:0]   pc4;
    logic          valid;
    logic [CW-1:0] count;

    modport master (
        output mem_req, mem_addr, inst, pc, pc4, valid, count,
        input  mem_ack, mem_rdata, hold, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, inst, pc, pc4, valid, count,
        output mem_ack, mem_rdata, hold, redirect, redirect_pc
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: fetches sequential words from a req/ack memory
// port into a small FIFO feeding the IF stage, honouring stall and redirect.
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    if_prefetch_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_n;
    logic          mem_req_q, mem_req_n;
    logic [31:0]   mem_addr_q, mem_addr_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q, count_n;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          push, pop, room, valid;
    logic [31:0]   new_pc;

    assign new_pc  = {bus.redirect_pc[31:2], 2'b00};
    assign valid   = (count_q != '0);
    assign push    = (state == REQ) && bus.mem_ack && !bus.redirect;
    assign pop     = valid && !bus.hold && !bus.redirect;
    assign count_n = bus.redirect ? '0 : count_q + CW'(push) - CW'(pop);
    // Only request another word if it is guaranteed a free slot when it lands
    assign room    = (count_n < CW'(DEPTH));

    // Next-state and request logic
    always_comb begin
        state_n    = state;
        mem_req_n  = mem_req_q;
        mem_addr_n = mem_addr_q;
        fetch_pc_n = fetch_pc;
        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_n = new_pc;
                end else if (room) begin
                    state_n    = REQ;
                    mem_req_n  = 1'b1;
                    mem_addr_n = fetch_pc;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (bus.redirect) begin
                        fetch_pc_n = new_pc;
                        mem_addr_n = new_pc;
                    end else begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        if (room) begin
                            mem_addr_n = fetch_pc + 32'd4;
                        end else begin
                            state_n   = IDLE;
                            mem_req_n = 1'b0;
                        end
                    end
                end else if (bus.redirect) begin
                    state_n    = DROP;
                    fetch_pc_n = new_pc;
                end
            end
            DROP: begin
                // The abandoned request must be held until it is acked
                if (bus.redirect) begin
                    fetch_pc_n = new_pc;
                end
                if (bus.mem_ack) begin
                    state_n    = REQ;
                    mem_addr_n = bus.redirect ? new_pc : fetch_pc;
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

    // FSM and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc   <= RESET_PC;
        end else begin
            state      <= state_n;
            mem_req_q  <= mem_req_n;
            mem_addr_q <= mem_addr_n;
            fetch_pc   <= fetch_pc_n;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_n;
        end
    end

    // FIFO storage; contents are only observable through the valid-gated head
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= mem_addr_q;
            inst_mem[wr_ptr] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.valid    = valid;
    assign bus.count    = count_q;
    assign bus.inst     = valid ? inst_mem[rd_ptr] : 32'd0;
    assign bus.pc       = valid ? pc_mem[rd_ptr] : 32'd0;
    assign bus.pc4      = valid ? pc_mem[rd_ptr] + 32'd4 : 32'd0;
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, stall, redirect (plain, DROP,
// with ack), address wrap on a second instance, and asynchronous reset.
module tb_if_prefetch;
    logic clk = 1'b0;
    logic reset;
    int   ack_wait;
    int   wcnt;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    if_prefetch_if #(.DEPTH(4)) a_bus ();
    if_prefetch_if #(.DEPTH(4)) b_bus ();

    if_prefetch #(.DEPTH(4), .RESET_PC(32'd0)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_bus)
    );

    if_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_bus)
    );

    // Memory for instance a: acks once a request has waited ack_wait cycles
    always @(posedge clk or posedge reset) begin
        if (reset)                              wcnt <= 0;
        else if (a_bus.mem_req && a_bus.mem_ack) wcnt <= 0;
        else if (a_bus.mem_req)                  wcnt <= wcnt + 1;
    end

    always_comb begin
        a_bus.mem_ack   = a_bus.mem_req && (wcnt >= ack_wait);
        a_bus.mem_rdata = (a_bus.mem_req && a_bus.mem_ack) ? ~a_bus.mem_addr : 32'hDEAD_BEEF;
    end

    // Instance b: zero-wait memory, free-running pipeline
    assign b_bus.mem_ack     = 1'b1;
    assign b_bus.mem_rdata   = ~b_bus.mem_addr;
    assign b_bus.hold        = 1'b0;
    assign b_bus.redirect    = 1'b0;
    assign b_bus.redirect_pc = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("count_le_depth", 32'(a_bus.count <= 3'd4), 32'd1);
    endtask

    initial begin
        reset             = 1'b1;
        ack_wait          = 0;
        a_bus.hold        = 1'b0;
        a_bus.redirect    = 1'b0;
        a_bus.redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_valid",    32'(a_bus.valid),   32'd0);
        chk("rst_count",    32'(a_bus.count),   32'd0);
        chk("rst_mem_req",  32'(a_bus.mem_req), 32'd0);
        chk("rst_mem_addr", a_bus.mem_addr,     32'd0);
        chk("rst_inst",     a_bus.inst,         32'd0);
        chk("rst_pc",       a_bus.pc,           32'd0);
        chk("rst_pc4",      a_bus.pc4,          32'd0);
        chk("rst_b_addr",   b_bus.mem_addr,     32'hFFFF_FFF8);

        // Streaming with zero-wait memory
        reset = 1'b0;
        step();
        chk("e1_mem_req", 32'(a_bus.mem_req), 32'd1);
        chk("e1_valid",   32'(a_bus.valid),   32'd0);
        chk("e1_b_req",   32'(b_bus.mem_req), 32'd1);
        step();
        chk("e2_valid", 32'(a_bus.valid), 32'd1);
        chk("e2_count", 32'(a_bus.count), 32'd1);
        chk("e2_pc",    a_bus.pc,   32'd0);
        chk("e2_inst",  a_bus.inst, 32'hFFFF_FFFF);
        chk("e2_pc4",   a_bus.pc4,  32'd4);
        chk("wrap_pc0",  b_bus.pc,  32'hFFFF_FFF8);
        chk("wrap_pc40", b_bus.pc4, 32'hFFFF_FFFC);
        step();
        chk("e3_pc",    a_bus.pc,   32'd4);
        chk("wrap_pc1", b_bus.pc,   32'hFFFF_FFFC);
        chk("wrap_pc41", b_bus.pc4, 32'd0);
        chk("wrap_inst1", b_bus.inst, 32'd3);
        step();
        chk("e4_pc",    a_bus.pc,   32'd8);
        chk("e4_inst",  a_bus.inst, 32'hFFFF_FFF7);
        chk("wrap_pc2", b_bus.pc,   32'd0);
        step();
        chk("e5_pc",    a_bus.pc,   32'd12);
        chk("e5_count", 32'(a_bus.count), 32'd1);
        chk("wrap_pc3", b_bus.pc,   32'd4);

        // Stall: FIFO fills to depth and the request stops
        a_bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold_count",   32'(a_bus.count),   32'd4);
        chk("hold_mem_req", 32'(a_bus.mem_req), 32'd0);
        chk("hold_pc",      a_bus.pc,           32'd12);
        a_bus.hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("drain_valid", 32'(a_bus.valid), 32'd1);
            chk("drain_pc",    a_bus.pc,         32'(16 + 4 * i));
        end

        // Redirect while a slow request is outstanding -> DROP
        reset    = 1'b1;
        ack_wait = 2;
        step();
        reset = 1'b0;
        step();
        chk("drop_req0",  32'(a_bus.mem_req), 32'd1);
        chk("drop_addr0", a_bus.mem_addr,     32'd0);
        a_bus.redirect    = 1'b1;
        a_bus.redirect_pc = 32'h40;
        step();
        a_bus.redirect = 1'b0;
        chk("drop_req1",  32'(a_bus.mem_req), 32'd1);
        chk("drop_addr1", a_bus.mem_addr,     32'd0);
        chk("drop_valid1", 32'(a_bus.valid),  32'd0);
        step();
        chk("drop_addr2", a_bus.mem_addr, 32'd0);
        step();
        chk("drop_addr3",  a_bus.mem_addr,   32'h40);
        chk("drop_valid3", 32'(a_bus.valid), 32'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!a_bus.valid && n < 10);
        chk("drop_valid", 32'(a_bus.valid), 32'd1);
        chk("drop_lat",   32'(n),          32'd3);
        chk("drop_pc",    a_bus.pc,        32'h40);
        chk("drop_inst",  a_bus.inst,      32'hFFFF_FFBF);

        // Redirect coinciding with ack and pop
        ack_wait = 0;
        step();
        chk("ra_pc0", a_bus.pc, 32'h44);
        a_bus.redirect    = 1'b1;
        a_bus.redirect_pc = 32'h100;
        step();
        a_bus.redirect = 1'b0;
        chk("ra_valid", 32'(a_bus.valid),   32'd0);
        chk("ra_count", 32'(a_bus.count),   32'd0);
        chk("ra_pc",    a_bus.pc,           32'd0);
        chk("ra_addr",  a_bus.mem_addr,     32'h100);
        chk("ra_req",   32'(a_bus.mem_req), 32'd1);
        step();
        chk("ra_valid1", 32'(a_bus.valid), 32'd1);
        chk("ra_pc1",    a_bus.pc,   32'h100);
        chk("ra_inst1",  a_bus.inst, 32'hFFFF_FEFF);
        chk("ra_pc41",   a_bus.pc4,  32'h104);
        step();
        chk("ra_pc2", a_bus.pc, 32'h104);

        // Redirect beats hold; low address bits are dropped
        a_bus.hold        = 1'b1;
        a_bus.redirect    = 1'b1;
        a_bus.redirect_pc = 32'h203;
        step();
        a_bus.hold     = 1'b0;
        a_bus.redirect = 1'b0;
        chk("rh_count", 32'(a_bus.count), 32'd0);
        chk("rh_addr",  a_bus.mem_addr,   32'h200);
        step();
        chk("rh_pc", a_bus.pc, 32'h200);

        // Asynchronous reset while a request is pending
        a_bus.hold = 1'b1;
        ack_wait   = 100;
        step();
        chk("ar_count_pre", 32'(a_bus.count),   32'd1);
        chk("ar_req_pre",   32'(a_bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req",   32'(a_bus.mem_req), 32'd0);
        chk("ar_valid", 32'(a_bus.valid),   32'd0);
        chk("ar_count", 32'(a_bus.count),   32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        ack_wait   = 0;
        a_bus.hold = 1'b0;
        step();
        chk("ar_restart_req",  32'(a_bus.mem_req), 32'd1);
        chk("ar_restart_addr", a_bus.mem_addr,     32'd0);
        step();
        chk("ar_restart_valid", 32'(a_bus.valid), 32'd1);
        chk("ar_restart_pc",    a_bus.pc,         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
